imem_loader: RTL and testbench

//  Writer side of the fetch-stage instruction memory: boots the pipelined CPU by

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the fetch-stage instruction memory. A byte stream is
//   assembled little-endian into 32-bit words. Each word is written through the
//   memory write port in a dedicated one-cycle WRITE state. The fetch stall is
//   held high from reset until the whole image has landed.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     When defined, the image is followed by 4 more bytes. These hold the
//     little-endian 32-bit sum of all written words. A wrong sum raises error
//     and returns to IDLE with the CPU still stalled. When the macro is not
//     defined, there is no CHECK state.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   1-cycle pulse that begins a load (honoured in IDLE/DONE only)
//   length     in   image size in words, sampled with start
//   in_valid   in   byte stream valid
//   in_data    in   byte stream data
//   in_ready   out  a byte is taken this cycle when in_valid is also high
//   imem_we    out  instruction memory write strobe (one cycle per word)
//   imem_addr  out  word address of the write
//   imem_wdata out  word written
//   stall      out  1 holds PC/fetch (PC enable = ~stall)
//   done       out  image loaded, CPU released
//   error      out  sticky load failure, cleared by the next start
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
`endif

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_WORDS);

  logic [2:0]          state;
  logic [ADDR_WIDTH:0] lenReg;
  logic [ADDR_WIDTH:0] wordIdx;
  logic [1:0]          byteCnt;
  logic [23:0]         lowBytes;   // bytes 0..2 of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         sum;
`endif

  logic                accept;
  logic [31:0]         fullWord;
  logic [ADDR_WIDTH:0] nextIdx;

  always_comb begin
    in_ready = (state == RECV);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHECK) in_ready = 1'b1;
`endif
  end

  assign accept   = in_valid && in_ready;
  // The 4th byte is used straight off the input, so the word is ready the same edge.
  assign fullWord = {in_data, lowBytes};
  assign nextIdx  = wordIdx + 1'b1;
  assign done     = (state == DONE);
  assign stall    = ~done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lenReg     <= '0;
      wordIdx    <= '0;
      byteCnt    <= '0;
      lowBytes   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      // Strobe is raised only on the edge that enters WRITE. That keeps it to
      // exactly the WRITE cycle while addr/wdata hold their last value.
      imem_we <= 1'b0;

      // Byte lanes 0..2 are banked here. Lane 3 completes the word in the state logic.
      if (accept) begin
        byteCnt <= byteCnt + 2'd1;
        case (byteCnt)
          2'd0:    lowBytes[7:0]   <= in_data;
          2'd1:    lowBytes[15:8]  <= in_data;
          2'd2:    lowBytes[23:16] <= in_data;
          default: ;
        endcase
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            error   <= 1'b0;
            wordIdx <= '0;
            byteCnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
            if (length == '0) begin
              state <= DONE;
            end else if (length > MAX_LEN) begin
              error <= 1'b1;
              state <= IDLE;
            end else begin
              lenReg <= length;
              state  <= RECV;
            end
          end
        end
        RECV: begin
          if (accept && byteCnt == 2'd3) begin
            imem_we    <= 1'b1;
            imem_addr  <= wordIdx[ADDR_WIDTH-1:0];
            imem_wdata <= fullWord;
            state      <= WRITE;
          end
        end
        WRITE: begin
          wordIdx <= nextIdx;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum     <= sum + imem_wdata;
          state   <= (nextIdx == lenReg) ? CHECK : RECV;
`else
          state   <= (nextIdx == lenReg) ? DONE : RECV;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept && byteCnt == 2'd3) begin
            if (fullWord == sum) begin
              state <= DONE;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, imem_we, stall, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .stall(stall), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Every write seen on the memory port.
  logic [AW-1:0] gotAddr[$];
  logic [31:0]   gotData[$];
  logic          prevWe = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      gotAddr.push_back(imem_addr);
      gotData.push_back(imem_wdata);
      checks++;
      if (in_ready !== 1'b0 || prevWe) begin
        fails++;
        $display("FAIL write_cycle: in_ready=%b prev_we=%b, required in_ready=0 and single-cycle strobe",
                 in_ready, prevWe);
      end
    end
    prevWe = imem_we;
  end

  // Reference model: words from a little-endian byte list, and their 32-bit sum.
  function automatic logic [31:0] modelWord(input logic [7:0] b[$], input int w);
    return 32'(b[4*w]) + (32'(b[4*w+1]) << 8) + (32'(b[4*w+2]) << 16) + (32'(b[4*w+3]) << 24);
  endfunction

  function automatic logic [31:0] modelSum(input logic [7:0] b[$]);
    logic [31:0] s = 0;
    for (int w = 0; w < b.size()/4; w++) s += modelWord(b, w);
    return s;
  endfunction

  // mode 0: continuous, 1: valid every other cycle, 2: random valid.
  // A byte offered but not taken stays offered with the same data.
  task automatic sendBytes(input logic [7:0] b[$], input int mode);
    int  i = 0, ph = 0, budget = 0;
    logic acc, holding = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      if (!holding) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ph[0];
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        ph++;
        in_data = in_valid ? b[i] : 8'($urandom);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      holding = in_valid && !acc;
      if (++budget > 4000) begin
        fails++;
        $display("FAIL send_timeout: sent %0d of %0d bytes", i, b.size());
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulseStart(input int n);
    @(negedge clk);
    start = 1'b1; length = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts a load of b, and appends the checksum when that feature is built in.
  task automatic doLoad(input logic [7:0] b[$], input int mode, input bit badSum);
    logic [7:0]  all[$];
    logic [31:0] s;
    gotAddr.delete(); gotData.delete();
    all = b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = badSum ? 32'h0 : modelSum(b);
    for (int k = 0; k < 4; k++) all.push_back(8'(s >> (8*k)));
`else
    s = 32'(badSum);
`endif
    pulseStart(b.size()/4);
    sendBytes(all, mode);
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gotAddr.delete(); gotData.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || error !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: stall=%b done=%b in_ready=%b error=%b, required 1 0 0 0",
                 stall, done, in_ready, error);
      end
    end
    checks++;
    if (gotAddr.size() != 0 || imem_addr !== '0 || imem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_mem_port: writes=%0d addr=%h wdata=%h, required 0 0 0",
               gotAddr.size(), imem_addr, imem_wdata);
    end
  endtask

  task automatic test_basic(input int mode, input string name);
    logic [7:0] b[$] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] exp[2] = '{32'h12345678, 32'hDEADBEEF};
    doLoad(b, mode, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL %s_checksum_done: done=%b stall=%b error=%b, required 1 0 0", name, done, stall, error);
    end
`else
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b1 || done !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL %s_lat1: we=%b done=%b stall=%b, required 1 0 1", name, imem_we, done, stall);
    end
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || done !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL %s_lat2: we=%b done=%b stall=%b, required 0 1 0", name, imem_we, done, stall);
    end
`endif
    checks++;
    if (gotAddr.size() != 2) begin
      fails++;
      $display("FAIL %s_count: %0d writes, required 2", name, gotAddr.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (gotAddr[w] !== AW'(w) || gotData[w] !== exp[w]) begin
          fails++;
          $display("FAIL %s_word%0d: addr=%h data=%h, required %h %h", name, w, gotAddr[w], gotData[w], w, exp[w]);
        end
      end
    end
  endtask

  task automatic test_zero_and_overflow;
    gotAddr.delete(); gotData.delete();
    pulseStart(0);
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || gotAddr.size() != 0) begin
      fails++;
      $display("FAIL zero_len: done=%b stall=%b writes=%0d, required 1 0 0", done, stall, gotAddr.size());
    end
    pulseStart(MAXW + 1);
    repeat (3) begin
      checks++;
      if (error !== 1'b1 || stall !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL over_len: error=%b stall=%b in_ready=%b done=%b, required 1 1 0 0",
                 error, stall, in_ready, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midload;
    logic [7:0] part[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] b[$]    = '{8'h04, 8'h03, 8'h02, 8'h01};
    logic [7:0] h1[$], h2[$];
    gotAddr.delete(); gotData.delete();
    pulseStart(2);
    sendBytes(part, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++;
    if (gotAddr.size() != 1 || gotData[0] !== 32'h44332211 || in_ready !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL midload_reset: writes=%0d in_ready=%b stall=%b done=%b, required 1 0 1 0",
               gotAddr.size(), in_ready, stall, done);
    end
    // Fresh length=1 load with a stray start (length 5) pulsed halfway through.
    h1 = '{b[0], b[1]};
    h2 = '{b[2], b[3]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    h2.push_back(8'h04); h2.push_back(8'h03); h2.push_back(8'h02); h2.push_back(8'h01);
`endif
    gotAddr.delete(); gotData.delete();
    pulseStart(1);
    sendBytes(h1, 0);
    pulseStart(5);
    sendBytes(h2, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (gotAddr.size() != 1 || gotAddr[0] !== '0 || gotData[0] !== 32'h01020304 || done !== 1'b1) begin
      fails++;
      $display("FAIL midload_reload: writes=%0d done=%b, required single write 0:01020304 and done=1",
               gotAddr.size(), done);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 5);
      logic [7:0] b[$];
      for (int k = 0; k < 4*n; k++) b.push_back(8'($urandom));
      doLoad(b, 2, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b1 || gotAddr.size() != n) begin
        fails++;
        $display("FAIL rand%0d_done: done=%b writes=%0d, required 1 %0d", it, done, gotAddr.size(), n);
      end else begin
        for (int w = 0; w < n; w++) begin
          checks++;
          if (gotAddr[w] !== AW'(w) || gotData[w] !== modelWord(b, w)) begin
            fails++;
            $display("FAIL rand%0d_word%0d: addr=%h data=%h, required %h %h",
                     it, w, gotAddr[w], gotData[w], w, modelWord(b, w));
          end
        end
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum;
    logic [7:0] b[$] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    doLoad(b, 0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (error !== 1'b1 || stall !== 1'b1 || done !== 1'b0 || gotAddr.size() != 2) begin
      fails++;
      $display("FAIL bad_checksum: error=%b stall=%b done=%b writes=%0d, required 1 1 0 2",
               error, stall, done, gotAddr.size());
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "toggle");
    test_zero_and_overflow();
    test_reset_midload();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
